// File: rtl/risc_core_pkg.sv
// Shared definitions for the parametrised accumulator core: opcode encodings,
// FSM state encoding and an opcode-field extraction helper.
// Ports: none (package).
package risc_core_pkg;

    localparam int unsigned OPC_W = 3;
    localparam int unsigned MAX_W = 64;

    localparam logic [OPC_W-1:0] OP_HLT = 3'b000;
    localparam logic [OPC_W-1:0] OP_SKZ = 3'b001;
    localparam logic [OPC_W-1:0] OP_ADD = 3'b010;
    localparam logic [OPC_W-1:0] OP_AND = 3'b011;
    localparam logic [OPC_W-1:0] OP_XOR = 3'b100;
    localparam logic [OPC_W-1:0] OP_LDA = 3'b101;
    localparam logic [OPC_W-1:0] OP_STO = 3'b110;
    localparam logic [OPC_W-1:0] OP_JMP = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FETCH = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    // Opcode is the top three bits of a data_w-wide instruction word.
    function automatic logic [OPC_W-1:0] opcode_of(input logic [MAX_W-1:0] word,
                                                   input int unsigned     data_w);
        return OPC_W'(word >> (data_w - OPC_W));
    endfunction

endpackage

// File: rtl/risc_core_mem.sv
// Unified instruction/data memory: 2^ADDR_W x DATA_W register array.
// Ports: clock; we/waddr/wdata single write port (synchronous);
//        fetch_addr -> fetch_data_c and oper_addr -> oper_data_c, two
//        combinational read ports. Contents are not reset.
module risc_core_mem
    import risc_core_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data_c,
    input  logic [ADDR_W-1:0] oper_addr,
    output logic [DATA_W-1:0] oper_data_c
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read ports
    assign fetch_data_c = mem_q[fetch_addr];
    assign oper_data_c  = mem_q[oper_addr];

endmodule

// File: rtl/risc_core_param.sv
// Parametrised accumulator CPU, eight-opcode ISA, two-cycle FETCH/EXEC schedule.
// Optional feature macro: RISC_CORE_CARRY_EN (adds the carry output/flag).
// Ports: clock; reset (async, active-low); load/load_addr/data_in program load;
//        run execute enable; Instruction (IR), Acc, Mem (last EXEC operand),
//        Program_counter, halted; carry (only with RISC_CORE_CARRY_EN).
module risc_core_param
    import risc_core_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              run,
    output logic [DATA_W-1:0] Instruction,
    output logic [DATA_W-1:0] Acc,
    output logic [DATA_W-1:0] Mem,
    output logic [ADDR_W-1:0] Program_counter,
    output logic              halted
`ifdef RISC_CORE_CARRY_EN
   ,output logic              carry
`endif
);

    state_t            state, state_d;
    logic [ADDR_W-1:0] pc_d;
    logic [DATA_W-1:0] ir_d, acc_d, mem_d;
    logic              halted_d;
`ifdef RISC_CORE_CARRY_EN
    logic              carry_d;
`endif

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] fetch_data_c, oper_data_c;
    logic [ADDR_W-1:0] oper_addr_c;
    logic [OPC_W-1:0]  opcode_c;
    logic              skip_c;

    assign oper_addr_c = Instruction[ADDR_W-1:0];
    assign opcode_c    = opcode_of(MAX_W'(Instruction), DATA_W);

`ifdef RISC_CORE_CARRY_EN
    assign skip_c = (Acc == '0) || carry;
`else
    assign skip_c = (Acc == '0);
`endif

    risc_core_mem #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clock       (clock),
        .we          (mem_we),
        .waddr       (mem_waddr),
        .wdata       (mem_wdata),
        .fetch_addr  (Program_counter),
        .fetch_data_c(fetch_data_c),
        .oper_addr   (oper_addr_c),
        .oper_data_c (oper_data_c)
    );

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            Program_counter <= '0;
            Instruction     <= '0;
            Acc             <= '0;
            Mem             <= '0;
            halted          <= 1'b0;
`ifdef RISC_CORE_CARRY_EN
            carry           <= 1'b0;
`endif
        end else begin
            state           <= state_d;
            Program_counter <= pc_d;
            Instruction     <= ir_d;
            Acc             <= acc_d;
            Mem             <= mem_d;
            halted          <= halted_d;
`ifdef RISC_CORE_CARRY_EN
            carry           <= carry_d;
`endif
        end
    end

    // Next state, datapath updates and memory write mux; load overrides everything
    always_comb begin
        state_d   = state;
        pc_d      = Program_counter;
        ir_d      = Instruction;
        acc_d     = Acc;
        mem_d     = Mem;
`ifdef RISC_CORE_CARRY_EN
        carry_d   = carry;
`endif
        mem_we    = 1'b0;
        mem_waddr = load_addr;
        mem_wdata = data_in;

        if (load) begin
            state_d = ST_LOAD;
            mem_we  = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state_d = ST_FETCH;
                    end
                end
                ST_LOAD: begin
                    state_d = ST_IDLE;
                    pc_d    = '0;
                    acc_d   = '0;
                    ir_d    = '0;
                end
                ST_FETCH: begin
                    if (run) begin
                        ir_d    = fetch_data_c;
                        pc_d    = Program_counter + ADDR_W'(1);
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state_d = ST_FETCH;
                    mem_d   = oper_data_c;
                    case (opcode_c)
                        OP_HLT: state_d = ST_HALT;
                        OP_SKZ: begin
                            if (skip_c) begin
                                pc_d = Program_counter + ADDR_W'(1);
                            end
                        end
                        OP_ADD: begin
`ifdef RISC_CORE_CARRY_EN
                            {carry_d, acc_d} = {1'b0, Acc} + {1'b0, oper_data_c};
`else
                            acc_d = Acc + oper_data_c;
`endif
                        end
                        OP_AND: begin
                            acc_d = Acc & oper_data_c;
`ifdef RISC_CORE_CARRY_EN
                            carry_d = 1'b0;
`endif
                        end
                        OP_XOR: begin
                            acc_d = Acc ^ oper_data_c;
`ifdef RISC_CORE_CARRY_EN
                            carry_d = 1'b0;
`endif
                        end
                        OP_LDA: begin
                            acc_d = oper_data_c;
`ifdef RISC_CORE_CARRY_EN
                            carry_d = 1'b0;
`endif
                        end
                        OP_STO: begin
                            mem_we    = 1'b1;
                            mem_waddr = oper_addr_c;
                            mem_wdata = Acc;
                        end
                        OP_JMP: pc_d = oper_addr_c;
                        default: ;
                    endcase
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_IDLE;
            endcase
        end

        halted_d = (state_d == ST_HALT);
    end

endmodule

// File: tb/tb_risc_core_param.sv
// Self-checking bench for risc_core_param: table of small programs with a
// scoreboard of expected end states, plus hand-written reset/load/wide-config
// sequences.
module tb_risc_core_param;

    logic       clock = 1'b0;
    logic       reset;
    logic       load, run;
    logic [4:0] load_addr;
    logic [7:0] data_in;
    logic [7:0] Instruction, Acc, Mem;
    logic [4:0] Program_counter;
    logic       halted;
`ifdef RISC_CORE_CARRY_EN
    logic       carry;
    logic       w_carry;
`endif

    logic        w_load, w_run;
    logic [8:0]  w_addr;
    logic [11:0] w_data;
    logic [11:0] w_ir, w_acc, w_mem;
    logic [8:0]  w_pc;
    logic        w_halted;

    always #5 clock = ~clock;

    risc_core_param #(.DATA_W(8), .ADDR_W(5)) u_dut (
        .clock          (clock),
        .reset          (reset),
        .load           (load),
        .load_addr      (load_addr),
        .data_in        (data_in),
        .run            (run),
        .Instruction    (Instruction),
        .Acc            (Acc),
        .Mem            (Mem),
        .Program_counter(Program_counter),
        .halted         (halted)
`ifdef RISC_CORE_CARRY_EN
       ,.carry          (carry)
`endif
    );

    risc_core_param #(.DATA_W(12), .ADDR_W(9)) u_dut_w (
        .clock          (clock),
        .reset          (reset),
        .load           (w_load),
        .load_addr      (w_addr),
        .data_in        (w_data),
        .run            (w_run),
        .Instruction    (w_ir),
        .Acc            (w_acc),
        .Mem            (w_mem),
        .Program_counter(w_pc),
        .halted         (w_halted)
`ifdef RISC_CORE_CARRY_EN
       ,.carry          (w_carry)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned id;
        logic [4:0]  addr;
        logic [7:0]  data;
    } word_t;

    typedef struct {
        string       name;
        int unsigned cycles;
        int unsigned probe_cyc;
        logic [4:0]  probe_pc;
        logic [7:0]  probe_mem;
        logic [7:0]  acc;
        logic [4:0]  pc;
        logic [7:0]  mem;
        logic        carry;
    } vec_t;

    word_t prog[$];
    vec_t  vecs[5];
    vec_t  sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic add_word(input int unsigned id, input logic [4:0] a, input logic [7:0] d);
        word_t w;
        w.id = id; w.addr = a; w.data = d;
        prog.push_back(w);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic load_prog(input int unsigned id);
        load = 1'b1;
        foreach (prog[k]) begin
            if (prog[k].id == id) begin
                load_addr = prog[k].addr;
                data_in   = prog[k].data;
                step();
            end
        end
        load = 1'b0;
        step();
    endtask

    // Run with a cycle bound; optionally sample PC/Mem after edge 'probe'.
    task automatic run_prog(input string tag, input int unsigned probe,
                            input logic [4:0] ppc, input logic [7:0] pmem,
                            output int unsigned cyc, output bit done);
        cyc  = 0;
        done = 1'b0;
        run  = 1'b1;
        while (!done && cyc < 60) begin
            step();
            cyc++;
            if (cyc == probe) begin
                check({tag, ".probe_pc"}, 32'(Program_counter), 32'(ppc));
                check({tag, ".probe_mem"}, 32'(Mem), 32'(pmem));
            end
            if (halted) done = 1'b1;
        end
        run = 1'b0;
    endtask

    initial begin
        int unsigned cyc;
        bit          done;
        vec_t        exp;

        reset = 1'b0; load = 1'b0; run = 1'b0; load_addr = '0; data_in = '0;
        w_load = 1'b0; w_run = 1'b0; w_addr = '0; w_data = '0;

        // Programs
        add_word(0, 5'h00, 8'hBB); add_word(0, 5'h01, 8'h00); add_word(0, 5'h1B, 8'hAA);
        add_word(1, 5'h00, 8'hBC); add_word(1, 5'h01, 8'h5A); add_word(1, 5'h02, 8'h20);
        add_word(1, 5'h03, 8'h00); add_word(1, 5'h04, 8'h00);
        add_word(1, 5'h1C, 8'hFF); add_word(1, 5'h1A, 8'h01);
        add_word(2, 5'h00, 8'hBE); add_word(2, 5'h01, 8'hDD); add_word(2, 5'h02, 8'hBD);
        add_word(2, 5'h03, 8'h00); add_word(2, 5'h1E, 8'h55); add_word(2, 5'h1D, 8'h33);
        add_word(3, 5'h00, 8'hFF); add_word(3, 5'h1F, 8'h20); add_word(3, 5'h01, 8'h00);
        add_word(4, 5'h00, 8'hBC); add_word(4, 5'h01, 8'h20); add_word(4, 5'h02, 8'h7B);
        add_word(4, 5'h03, 8'h9A); add_word(4, 5'h04, 8'h00);
        add_word(4, 5'h1C, 8'h01); add_word(4, 5'h1B, 8'h03); add_word(4, 5'h1A, 8'h0F);

        //          name       cyc probe ppc    pmem   acc    pc     mem    carry
        vecs[0] = '{"ldahlt",   5, 3,  5'h01, 8'hAA, 8'hAA, 5'h02, 8'hBB, 1'b0};
        vecs[1] = '{"addskz",   9, 5,  5'h02, 8'h01, 8'h00, 5'h05, 8'hBC, 1'b1};
        vecs[2] = '{"stolda",   9, 5,  5'h02, 8'h33, 8'h55, 5'h04, 8'hBE, 1'b0};
        vecs[3] = '{"jmpwrap",  7, 5,  5'h01, 8'hFF, 8'h00, 5'h02, 8'hFF, 1'b0};
        vecs[4] = '{"skzxor",  11, 5,  5'h02, 8'hBC, 8'h0E, 5'h05, 8'hBC, 1'b0};

        // Reset state
        #3;
        check("rst.acc", 32'(Acc), 0);
        check("rst.pc", 32'(Program_counter), 0);
        check("rst.ir", 32'(Instruction), 0);
        check("rst.mem", 32'(Mem), 0);
        check("rst.halted", 32'(halted), 0);
`ifdef RISC_CORE_CARRY_EN
        check("rst.carry", 32'(carry), 0);
`endif
        step();
        reset = 1'b1;
        step();

        // Table-driven programs
        for (int i = 0; i < 5; i++) begin
            do_reset();
            load_prog(i);
            sb.push_back(vecs[i]);
            run_prog(vecs[i].name, vecs[i].probe_cyc, vecs[i].probe_pc, vecs[i].probe_mem, cyc, done);
            exp = sb.pop_front();
            check({exp.name, ".done"}, 32'(done), 1);
            check({exp.name, ".cycles"}, cyc, exp.cycles);
            check({exp.name, ".acc"}, 32'(Acc), 32'(exp.acc));
            check({exp.name, ".pc"}, 32'(Program_counter), 32'(exp.pc));
            check({exp.name, ".ir"}, 32'(Instruction), 0);
            check({exp.name, ".mem"}, 32'(Mem), 32'(exp.mem));
`ifdef RISC_CORE_CARRY_EN
            check({exp.name, ".carry"}, 32'(carry), 32'(exp.carry));
`endif
            // HALT ignores run
            run = 1'b1;
            step(); step();
            run = 1'b0;
            check({exp.name, ".halt_hold"}, 32'(Program_counter), 32'(exp.pc));
        end

        // Async reset during EXEC of ADD, memory retained
        do_reset();
        load_prog(1);
        run = 1'b1;
        for (int k = 0; k < 4; k++) step();
        check("rstexec.pre_acc", 32'(Acc), 32'h0FF);
        #2 reset = 1'b0;
        #1;
        check("rstexec.acc", 32'(Acc), 0);
        check("rstexec.pc", 32'(Program_counter), 0);
        check("rstexec.ir", 32'(Instruction), 0);
        check("rstexec.mem", 32'(Mem), 0);
        run = 1'b0;
        step();
        reset = 1'b1;
        step();
        run_prog("rerun", 0, 5'h00, 8'h00, cyc, done);
        check("rerun.done", 32'(done), 1);
        check("rerun.acc", 32'(Acc), 0);
        check("rerun.pc", 32'(Program_counter), 5);

        // Load during EXEC aborts it; load beats run
        do_reset();
        load_prog(0);
        run = 1'b1;
        step(); step();
        check("abort.pre_ir", 32'(Instruction), 32'hBB);
        load = 1'b1; load_addr = 5'h10; data_in = 8'h77;
        step();
        check("abort.acc", 32'(Acc), 0);
        check("abort.mem", 32'(Mem), 0);
        load = 1'b0;
        step();
        check("abort.pc", 32'(Program_counter), 0);
        check("abort.ir", 32'(Instruction), 0);
        run_prog("abort2", 0, 5'h00, 8'h00, cyc, done);
        check("abort2.done", 32'(done), 1);
        check("abort2.acc", 32'(Acc), 32'hAA);
        load = 1'b1;
        step();
        check("halt_load.halted", 32'(halted), 0);
        load = 1'b0;
        step();

        // Wide configuration: LDA 0xFFF, JMP 0x1FF, ADD 0x001 at 0x1FF
        w_load = 1'b1;
        w_addr = 9'h000; w_data = 12'hA11; step();
        w_addr = 9'h001; w_data = 12'hFFF; step();
        w_addr = 9'h1FF; w_data = 12'h410; step();
        w_addr = 9'h010; w_data = 12'h001; step();
        w_addr = 9'h011; w_data = 12'hFFF; step();
        w_load = 1'b0;
        step();
        w_run = 1'b1;
        for (int k = 0; k < 5; k++) step();
        check("wide.jmp_pc", 32'(w_pc), 32'h1FF);
        step();
        check("wide.wrap_pc", 32'(w_pc), 0);
        check("wide.ir", 32'(w_ir), 32'h410);
        check("wide.pre_acc", 32'(w_acc), 32'hFFF);
        w_run = 1'b0;
        step();
        check("wide.acc", 32'(w_acc), 0);
        check("wide.mem", 32'(w_mem), 32'h001);
`ifdef RISC_CORE_CARRY_EN
        check("wide.carry", 32'(w_carry), 1);
`endif
        step();
        check("wide.hold_pc", 32'(w_pc), 0);
        check("wide.halted", 32'(w_halted), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
